// File: rtl/abcd_sweep_checker.sv
// rtl/abcd_sweep_checker.sv - clocked ABCD sweep driving F(A,B,C,D) and checking it against a golden table
// Each code is held SETTLE+1 cycles, F is sampled on the last one, and results are latched until restart.
module abcd_sweep_checker #(
    parameter logic [15:0] EXPECT = 16'hAAF8,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f_in,
    output logic [3:0] abcd,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_err_valid,
    output logic [3:0] first_err_idx,
    output logic       mismatch
);

    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] r_abcd;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [4:0] r_err_count;
    logic       r_first_err_valid;
    logic [3:0] r_first_err_idx;
    logic       r_mismatch;

    logic       w_start_ok;
    logic       w_sample;
    logic       w_mis;
    logic [4:0] w_err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_RUN;
                    w_start_ok   = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == 4'd0) begin
                    w_sample = 1'b1;
                    if (r_abcd == 4'd15) begin
                        w_state_next = S_DONE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_mis      = w_sample && (f_in != EXPECT[r_abcd]);
    assign w_err_next = r_err_count + {4'd0, w_mis};

    // The final sample's mismatch must count toward pass, hence w_err_next rather than r_err_count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt             <= 4'd0;
            r_abcd            <= 4'd0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= 5'd0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= 4'd0;
            r_mismatch        <= 1'b0;
        end else begin
            r_mismatch <= w_mis;
            if (w_start_ok) begin
                r_abcd            <= 4'd0;
                r_cnt             <= SETTLE_L;
                r_busy            <= 1'b1;
                r_done            <= 1'b0;
                r_pass            <= 1'b0;
                r_err_count       <= 5'd0;
                r_first_err_valid <= 1'b0;
                r_first_err_idx   <= 4'd0;
            end else if (r_state == S_RUN) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_err_count <= w_err_next;
                    if (w_mis && !r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_idx   <= r_abcd;
                    end
                    if (r_abcd != 4'd15) begin
                        r_abcd <= r_abcd + 4'd1;
                        r_cnt  <= SETTLE_L;
                    end else begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_next == 5'd0);
                    end
                end
            end
        end
    end

    assign abcd            = r_abcd;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign first_err_valid = r_first_err_valid;
    assign first_err_idx   = r_first_err_idx;
    assign mismatch        = r_mismatch;

endmodule

// File: tb/tb_abcd_sweep_checker.sv
// tb/tb_abcd_sweep_checker.sv - randomized fault-table sweeps of abcd_sweep_checker against a reference model
module tb_abcd_sweep_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start2 = 1'b0;
    logic start0 = 1'b0;
    logic f_in2, f_in0;
    logic [3:0] abcd2, abcd0, fei2, fei0;
    logic busy2, done2, pass2, fev2, mm2;
    logic busy0, done0, pass0, fev0, mm0;
    logic [4:0] err2, err0;

    logic [15:0] bad = 16'h0;
    bit sel0 = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    abcd_sweep_checker #(.EXPECT(16'hAAF8), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .f_in(f_in2), .abcd(abcd2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_valid(fev2), .first_err_idx(fei2), .mismatch(mm2)
    );

    abcd_sweep_checker #(.EXPECT(16'hAAF8), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .f_in(f_in0), .abcd(abcd0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_valid(fev0), .first_err_idx(fei0), .mismatch(mm0)
    );

    // Function block model: F is the product of maxterms 0,1,2,8,10,12,14; bad[] injects faults.
    function automatic bit f_gold(input logic [3:0] c);
        return !(c inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd10, 4'd12, 4'd14});
    endfunction

    always_comb f_in2 = f_gold(abcd2) ^ bad[abcd2];
    always_comb f_in0 = f_gold(abcd0) ^ bad[abcd0];

    logic [3:0] c_abcd, c_fei;
    logic c_busy, c_done, c_pass, c_fev, c_mm;
    logic [4:0] c_err;
    always_comb begin
        c_abcd = sel0 ? abcd0 : abcd2;
        c_fei  = sel0 ? fei0  : fei2;
        c_busy = sel0 ? busy0 : busy2;
        c_done = sel0 ? done0 : done2;
        c_pass = sel0 ? pass0 : pass2;
        c_fev  = sel0 ? fev0  : fev2;
        c_mm   = sel0 ? mm0   : mm2;
        c_err  = sel0 ? err0  : err2;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_start(input bit v);
        if (sel0) start0 = v;
        else      start2 = v;
    endtask

    // One full sweep; expectations derived from the fault table alone.
    task automatic run_sweep(input bit use0, input logic [15:0] tbl, input bit poke);
        int per, total, exp_err, exp_first, mm_seen, abcd_bad, flag_bad;
        bit exp_fev, exp_mm;
        per = use0 ? 1 : 3;
        total = 16 * per;
        exp_err = 0; exp_first = 0; exp_fev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i]) begin
                if (!exp_fev) exp_first = i;
                exp_fev = 1'b1;
                exp_err++;
            end
        end
        sel0 = use0;
        bad = tbl;
        mm_seen = 0; abcd_bad = 0; flag_bad = 0;
        @(negedge clk);
        drive_start(1'b1);
        for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            drive_start(poke && t == 9);
            exp_mm = (t > 0) && (t % per == 0) && tbl[t / per - 1];
            if (c_mm) mm_seen++;
            if (c_mm != exp_mm) begin
                chk("mismatch_pulse", c_mm, exp_mm);
            end
            if (t == 0) begin
                chk("start_err_clr", c_err, 0);
                chk("start_fev_clr", c_fev, 0);
                chk("start_pass_clr", c_pass, 0);
            end
            if (t < total) begin
                if (c_abcd != 4'(t / per)) abcd_bad++;
                if (!c_busy || c_done) flag_bad++;
            end else begin
                chk("abcd_steps", abcd_bad, 0);
                chk("busy_flags", flag_bad, 0);
                chk("done_at_end", c_done, 1);
                chk("busy_at_end", c_busy, 0);
                chk("abcd_final", c_abcd, 15);
                chk("err_count", c_err, exp_err);
                chk("pass", c_pass, exp_err == 0);
                chk("first_err_valid", c_fev, exp_fev);
                if (exp_fev) chk("first_err_idx", c_fei, exp_first);
                chk("mismatch_total", mm_seen, exp_err);
            end
        end
        @(negedge clk);
        chk("done_hold", c_done, 1);
        chk("err_hold", c_err, exp_err);
    endtask

    initial begin
        int found;
        repeat (2) @(negedge clk);
        chk("rst_abcd", abcd2, 0);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_err", err2, 0);
        chk("rst_mm", mm2, 0);
        chk("rst_done0", done0, 0);
        rst = 1'b0;

        run_sweep(1'b0, 16'h0000, 1'b0);
        chk("golden_err", err2, 0);
        run_sweep(1'b0, 16'hFFFF, 1'b0);
        chk("inverted_err", err2, 16);
        chk("inverted_first", fei2, 0);
        run_sweep(1'b0, 16'h5507, 1'b0);
        chk("stuck1_err", err2, 7);
        chk("stuck1_first", fei2, 0);
        run_sweep(1'b0, 16'h0200, 1'b0);
        chk("f9_err", err2, 1);
        chk("f9_first", fei2, 9);
        chk("f9_pass", pass2, 0);

        // Reset in the middle of a failing sweep.
        sel0 = 1'b0;
        bad = 16'hFFFF;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (abcd2 == 4'd5) found = 1;
        end
        chk("reach_abcd5", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_abcd", abcd2, 0);
        chk("midrst_busy", busy2, 0);
        chk("midrst_done", done2, 0);
        chk("midrst_pass", pass2, 0);
        chk("midrst_err", err2, 0);
        chk("midrst_fev", fev2, 0);
        chk("midrst_fei", fei2, 0);
        chk("midrst_mm", mm2, 0);
        repeat (3) @(negedge clk);
        chk("midrst_idle", busy2, 0);

        run_sweep(1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) run_sweep(1'b0, 16'($urandom), i[0]);

        run_sweep(1'b1, 16'h0000, 1'b0);
        run_sweep(1'b1, 16'h0000, 1'b0);
        run_sweep(1'b1, 16'h8001, 1'b0);
        for (int i = 0; i < 3; i++) run_sweep(1'b1, 16'($urandom), 1'b0);
        run_sweep(1'b1, 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
